// File: rtl/execute_stage_if.sv
// EX-stage bundle: ID/EX operands and control, MEM/WB forwarding taps, EX/MEM register and HI/LO.
// master drives the instruction side (decode/bench), slave is the execute stage.
interface execute_stage_if;
  logic [3:0]  ex_in;
  logic [2:0]  m_in;
  logic [1:0]  wb_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [31:0] imm_in;
  logic [31:0] data_1_in;
  logic [31:0] data_2_in;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  m_out;
  logic [1:0]  wb_out;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output ex_in, m_in, wb_in, rs_in, rt_in, rd_in, imm_in, data_1_in, data_2_in,
           wb_reg_write, wb_rd, wb_data,
    input  m_out, wb_out, alu_out, store_data, dest_reg, zero, hi, lo, busy
  );

  modport slave (
    input  ex_in, m_in, wb_in, rs_in, rt_in, rd_in, imm_in, data_1_in, data_2_in,
           wb_reg_write, wb_rd, wb_data,
    output m_out, wb_out, alu_out, store_data, dest_reg, zero, hi, lo, busy
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding, ALU and EX/MEM register (1 cycle); MULT/MULTU takes 32 extra cycles
// with busy asserted, during which EX/MEM loads bubbles and upstream must hold ID/EX.
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  execute_stage_if.slave bus
);
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [2:0]  m_q, m_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] alu_q, alu_d, sd_q, sd_d;
  logic [4:0]  dest_q, dest_d;
  logic        zero_q, zero_d;

  logic        exm_wr;
  logic        wbk_wr;
  logic [31:0] op_a, rt_fwd, op_b;
  logic [31:0] alu_res;
  logic        op_valid, is_mul, mul_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum;
  logic [63:0] step_prod, final_prod;

  // Only ALU results in EX/MEM can be forwarded; a pending load (MemtoReg) has no data yet.
  assign exm_wr = wb_q[1] & ~wb_q[0] & (dest_q != 5'd0);
  assign wbk_wr = bus.wb_reg_write & (bus.wb_rd != 5'd0);

  always_comb begin
    op_a = bus.data_1_in;
    if (exm_wr && dest_q == bus.rs_in) begin
      op_a = alu_q;
    end else if (wbk_wr && bus.wb_rd == bus.rs_in) begin
      op_a = bus.wb_data;
    end
    rt_fwd = bus.data_2_in;
    if (exm_wr && dest_q == bus.rt_in) begin
      rt_fwd = alu_q;
    end else if (wbk_wr && bus.wb_rd == bus.rt_in) begin
      rt_fwd = bus.wb_data;
    end
    op_b = bus.ex_in[0] ? bus.imm_in : rt_fwd;
  end

  always_comb begin
    alu_res    = 32'd0;
    op_valid   = 1'b1;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    case (bus.ex_in[2:1])
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (bus.imm_in[5:0])
          F_ADD:   alu_res = op_a + op_b;
          F_SUB:   alu_res = op_a - op_b;
          F_AND:   alu_res = op_a & op_b;
          F_OR:    alu_res = op_a | op_b;
          F_SLT:   alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
          F_SLL:   alu_res = op_b << bus.imm_in[10:6];
          F_MFHI:  alu_res = hi_q;
          F_MFLO:  alu_res = lo_q;
          F_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
          F_MULTU: is_mul = 1'b1;
          default: op_valid = 1'b0;
        endcase
      end
      default: op_valid = 1'b0;
    endcase
  end

  // Sign-magnitude multiply: unsigned shift-add on magnitudes, sign reapplied on the final step.
  assign mag_a      = (mul_signed && op_a[31]) ? -op_a : op_a;
  assign mag_b      = (mul_signed && op_b[31]) ? -op_b : op_b;
  assign add_sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign step_prod  = {add_sum, prod_q[31:1]};
  assign final_prod = neg_q ? -step_prod : step_prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = 3'd0;
    wb_d    = 2'd0;
    alu_d   = 32'd0;
    sd_d    = 32'd0;
    dest_d  = 5'd0;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (is_mul) begin
          state_d = MUL;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          mcand_d = mag_a;
          prod_d  = {32'd0, mag_b};
          neg_d   = mul_signed & (op_a[31] ^ op_b[31]);
        end else if (op_valid) begin
          m_d    = bus.m_in;
          wb_d   = bus.wb_in;
          alu_d  = alu_res;
          sd_d   = rt_fwd;
          dest_d = bus.ex_in[3] ? bus.rd_in : bus.rt_in;
          zero_d = (alu_res == 32'd0);
        end
      end
      MUL: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_CYCLES - 1)) begin
          hi_d    = final_prod[63:32];
          lo_d    = final_prod[31:0];
          cnt_d   = 5'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      mcand_q <= 32'd0;
      prod_q  <= 64'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      m_q     <= 3'd0;
      wb_q    <= 2'd0;
      alu_q   <= 32'd0;
      sd_q    <= 32'd0;
      dest_q  <= 5'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.m_out      = m_q;
  assign bus.wb_out     = wb_q;
  assign bus.alu_out    = alu_q;
  assign bus.store_data = sd_q;
  assign bus.dest_reg   = dest_q;
  assign bus.zero       = zero_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed program plus random instruction stream, both checked
// against an instruction-level model of EX/MEM, HI/LO and the multiplier busy window.
module tb_execute_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_stage_if bus ();
  execute_stage #(.MUL_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Model of the architectural state visible at the EX/MEM boundary.
  logic [2:0]  em;
  logic [1:0]  ewb;
  logic [31:0] ealu, esd, ehi, elo;
  logic [4:0]  edest;
  logic        ezero, ebusy;
  logic [63:0] pend;
  int          mleft;
  int          lvl;  // 0: control only, 1: +alu_out, 2: every output

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] a, rtv, b, res;
    logic        ok, mul, sgn;
    longint      sa, sb;
    if (reset) begin
      em = 0; ewb = 0; ealu = 0; esd = 0; edest = 0; ezero = 0;
      ehi = 0; elo = 0; ebusy = 0; mleft = 0; lvl = 2;
      return;
    end
    if (ebusy) begin
      em = 0; ewb = 0; ealu = 0; lvl = 0;
      mleft--;
      if (mleft == 0) begin
        ebusy = 0;
        {ehi, elo} = pend;
      end
      return;
    end
    a = bus.data_1_in;
    if (ewb == 2'b10 && edest != 0 && edest == bus.rs_in) a = ealu;
    else if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == bus.rs_in) a = bus.wb_data;
    rtv = bus.data_2_in;
    if (ewb == 2'b10 && edest != 0 && edest == bus.rt_in) rtv = ealu;
    else if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == bus.rt_in) rtv = bus.wb_data;
    b = bus.ex_in[0] ? bus.imm_in : rtv;
    ok = 1; mul = 0; sgn = 0; res = 0;
    if (bus.ex_in[2:1] == 2'd0) res = a + b;
    else if (bus.ex_in[2:1] == 2'd1) res = a - b;
    else if (bus.ex_in[2:1] == 2'd2) begin
      case (bus.imm_in[5:0])
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: res = b << bus.imm_in[10:6];
        6'h10: res = ehi;
        6'h12: res = elo;
        6'h18: begin mul = 1; sgn = 1; end
        6'h19: mul = 1;
        default: ok = 0;
      endcase
    end else ok = 0;
    if (mul) begin
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      pend = 64'(sa * sb);
      em = 0; ewb = 0; ealu = 0; lvl = 0;
      ebusy = 1; mleft = 32;
    end else if (!ok) begin
      em = 0; ewb = 0; ealu = 0; lvl = 1;
    end else begin
      em = bus.m_in; ewb = bus.wb_in; ealu = res; esd = rtv;
      edest = bus.ex_in[3] ? bus.rd_in : bus.rt_in;
      ezero = (res == 0); lvl = 2;
    end
  endtask

  task automatic compare();
    check("busy", bus.busy, ebusy);
    check("hi", bus.hi, ehi);
    check("lo", bus.lo, elo);
    check("m_out", bus.m_out, em);
    check("wb_out", bus.wb_out, ewb);
    if (lvl >= 1) check("alu_out", bus.alu_out, ealu);
    if (lvl == 2) begin
      check("store_data", bus.store_data, esd);
      check("dest_reg", bus.dest_reg, edest);
      check("zero", bus.zero, ezero);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic issue(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2,
                       input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    bus.ex_in = ex; bus.m_in = m; bus.wb_in = wb;
    bus.rs_in = rs; bus.rt_in = rt; bus.rd_in = rd; bus.imm_in = imm;
    bus.data_1_in = d1; bus.data_2_in = d2;
    bus.wb_reg_write = wbw; bus.wb_rd = wbrd; bus.wb_data = wbd;
    step();
  endtask

  function automatic logic [31:0] rnd_data();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20));
  endfunction

  task automatic rand_instr();
    logic [5:0]  fn;
    logic [31:0] imm;
    int          r;
    r = $urandom_range(0, 99);
    case ($urandom_range(0, 10))
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2a;
      5: fn = 6'h00; 6: fn = 6'h10; 7: fn = 6'h12; 8: fn = 6'h18; 9: fn = 6'h19;
      default: fn = 6'($urandom);
    endcase
    if ((fn == 6'h18 || fn == 6'h19) && $urandom_range(0, 7) != 0) fn = 6'h20;
    imm = {21'($urandom), 5'($urandom), fn};
    issue({1'($urandom), (r < 60) ? 2'b10 : 2'($urandom), (r < 60) ? 1'b0 : 1'($urandom)},
          3'($urandom), 2'($urandom),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          imm, rnd_data(), rnd_data(),
          1'($urandom), 5'($urandom_range(0, 3)), rnd_data());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    reset = 1'b1;
    issue(4'b0, 3'b0, 2'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(4'b0, 3'b0, 2'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // EX/MEM beats MEM/WB when both hold $1
    issue(4'b1001, 3'b000, 2'b10, 0, 0, 1, 32'd100, 0, 0, 0, 0, 0);
    issue(4'b1100, 3'b000, 2'b10, 1, 2, 3, 32'h20, 7, 5, 1, 1, 32'd50);
    check("fwd_priority_alu", bus.alu_out, 32'd105);
    check("fwd_priority_dest", bus.dest_reg, 5'd3);
    check("fwd_priority_wb", bus.wb_out, 2'b10);

    issue(4'b0001, 3'b010, 2'b11, 5, 6, 0, 32'h10, 32'h1000, 0, 0, 0, 0);
    check("lw_addr", bus.alu_out, 32'h1010);
    check("lw_m", bus.m_out, 3'b010);
    issue(4'b0001, 3'b001, 2'b00, 5, 4, 0, 32'h8, 32'h1000, 0, 1, 4, 32'hDEAD);
    check("sw_store_fwd", bus.store_data, 32'hDEAD);

    issue(4'b1100, 3'b000, 2'b10, 7, 8, 9, 32'h2a, 32'hFFFF_FFFF, 1, 0, 0, 0);
    check("slt_signed", bus.alu_out, 32'd1);
    issue(4'b1010, 3'b000, 2'b10, 7, 8, 9, 32'h0, 9, 9, 0, 0, 0);
    check("sub_zero", bus.zero, 1'b1);

    issue(4'b1001, 3'b000, 2'b10, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0);
    issue(4'b1001, 3'b000, 2'b10, 0, 0, 2, 32'h1, 0, 0, 0, 0, 0);
    check("no_fwd_r0", bus.alu_out, 32'd1);

    // mult -3 * 5, then mflo held in ID/EX across the busy window
    busy_cnt = 0;
    issue(4'b1100, 3'b000, 2'b00, 9, 10, 0, 32'h18, -32'sd3, 32'd5, 0, 0, 0);
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 33; i++) begin
      issue(4'b1100, 3'b000, 2'b10, 9, 10, 11, 32'h12, 0, 0, 0, 0, 0);
      if (bus.busy) busy_cnt++;
    end
    check("mult_busy_cycles", busy_cnt, 32);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFF1);
    check("mflo_after_mult", bus.alu_out, 32'hFFFF_FFF1);

    busy_cnt = 0;
    issue(4'b1100, 3'b000, 2'b00, 9, 10, 0, 32'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    for (int i = 0; i < 40 && bus.busy; i++) begin
      busy_cnt++;
      issue(4'b1001, 3'b000, 2'b10, 0, 0, 12, 32'h3, 0, 0, 0, 0, 0);
    end
    check("multu_busy_cycles", busy_cnt, 32);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    // reset during cycle N+10 of a mult
    issue(4'b1100, 3'b000, 2'b00, 9, 10, 0, 32'h18, 32'd6, 32'd7, 0, 0, 0);
    for (int i = 0; i < 9; i++) issue(4'b1100, 3'b000, 2'b10, 9, 10, 11, 32'h12, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_alu", bus.alu_out, 32'd0);
    issue(4'b1001, 3'b000, 2'b10, 0, 0, 3, 32'h7, 0, 0, 0, 0, 0);
    check("add_after_rst", bus.alu_out, 32'd7);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      rand_instr();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS-R2000 pipeline; consumes the ID/EX register outputs of the decode stage (ex/m/wb control, rs/rt/rd, imm, data_1/data_2) and produces the EX/MEM pipeline register.
- Contains the operand forwarding muxes, the ALU, and an iterative 32-cycle MULT/MULTU unit with HI/LO.
- Drives a busy stall request back to the decode and fetch stages.

Parameters:
- MUL_CYCLES, 32, number of iteration cycles of the multiplier; fixed at 32 (one per operand bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_in  in  4  [3] RegDst, [2:1] ALUOp (00 add, 01 sub, 10 funct), [0] ALUSrc
- m_in  in  3  [2] Branch, [1] MemRead, [0] MemWrite
- wb_in  in  2  [1] RegWrite, [0] MemtoReg
- rs_in, rt_in, rd_in  in  5 each  register numbers
- imm_in  in  32  immediate, zero-extended by decode; [5:0] funct, [10:6] shamt
- data_1_in, data_2_in  in  32  register-file values of rs and rt
- wb_reg_write  in  1  MEM/WB RegWrite
- wb_rd  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB write-back data
- m_out  out  3  EX/MEM memory control
- wb_out  out  2  EX/MEM write-back control
- alu_out  out  32  ALU result or memory address
- store_data  out  32  forwarded rt value for SW
- dest_reg  out  5  destination register
- zero  out  1  ALU result == 0
- hi, lo  out  32 each  multiplier result registers
- busy  out  1  multiplier running; upstream holds PC, IF/ID and ID/EX

Behaviour:
Clocking and reset:
- Single clock domain, posedge clk.
- reset is synchronous and active-high.
- On reset, all outputs are 0, the FSM goes to IDLE, and the counter is 0.
- Reset during MUL aborts the operation: the next cycle has busy=0 and hi=lo=0.

Forwarding (combinational on the ID/EX inputs):
- Operand A = data_1_in, overridden for rs_in, and operand B source = data_2_in, overridden for rt_in.
- Priority 1 (EX/MEM): wb_out[1]=1, wb_out[0]=0, dest_reg!=0 and dest_reg matches → use alu_out.
- Priority 2 (MEM/WB): wb_reg_write=1, wb_rd!=0 and wb_rd matches → use wb_data.
- Register 0 is never forwarded.
- store_data = forwarded rt value.
- ALU B = ALUSrc ? imm_in : forwarded rt.

ALU:
- ALUOp 00 → A+B; ALUOp 01 → A-B.
- ALUOp 10, funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or
  - 101010 slt (signed, result 0/1), 000000 sll (B << shamt)
  - 010000 mfhi, 010010 mflo
  - 011000 mult, 011001 multu
- Unknown funct → NOP: m_out=0, wb_out=0, alu_out=0.
- All arithmetic is 32-bit with wrap; no overflow exception.

EX/MEM register (every cycle while busy=0):
- Outputs take m_in, wb_in, the ALU result, store_data and zero.
- dest_reg = RegDst ? rd_in : rt_in.
- A mult/multu passes a bubble (m_out=0, wb_out=0).
- While busy=1 the EX/MEM register loads a bubble every cycle and the inputs are ignored; upstream holds ID/EX.

Multiplier FSM (IDLE, MUL):
- IDLE: a mult/multu presented in cycle N latches operand magnitudes and the result-sign flag (signed: sign(A) xor sign(B); multu: 0). Transition to MUL with counter=0.
- MUL: busy=1 in cycles N+1 … N+32; one shift-add step per cycle; counter increments.
  - At the end of cycle N+32: {hi,lo} = 64-bit product, two's-complement negated if the sign flag is set.
  - Transition to IDLE.
- busy=0 and new hi/lo are visible from N+33.
- The instruction held in ID/EX during MUL executes at N+33; mfhi/mflo there see the new values.
- busy is registered; it is never asserted in IDLE.

Test Plan:
- add $3,$1,$2 with data_1_in=7, data_2_in=5; previous instruction wrote $1=100 (in EX/MEM) and MEM/WB writes $1=50 → alu_out=105 (EX/MEM priority), dest_reg=3, wb_out=10.
- lw (ex_in=0001, imm=0x10, data_1_in=0x1000) → alu_out=0x1010, m_out=010. sw with MEM/WB forwarding rt=$4 ← 0xDEAD → store_data=0xDEAD.
- slt with A=0xFFFFFFFF, B=1 → alu_out=1. sub with A=B=9 → zero=1. EX/MEM dest_reg=0 with wb_out=10 → no forwarding to rs=0.
- mult A=-3, B=5 at cycle N → busy high exactly cycles N+1..N+32; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. EX/MEM is a bubble throughout. mflo held in ID/EX → alu_out=0xFFFFFFF1 at N+33.
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 32 busy cycles.
- reset asserted at cycle N+10 of a mult → next cycle busy=0, hi=lo=0, all outputs 0. A subsequent add executes normally.
